// File: rtl/stereo_bram_loader.sv
// Streams rectified ref/search pixel pairs into two ring-buffered row BRAMs (port A) for Disp_Map_Calc.
// Optional LOADER_ROWCNT_EN exposes the loaded-row counter as output rows_loaded.
module stereo_bram_loader #(
    parameter int NUM_OF_ROWS_IN_BRAM = 8,
    parameter int HRES                = 640,
    parameter int VRES                = 480,
    parameter int BRAM_DATA_WIDTH     = 16,
    parameter int BRAM_ADDR_WIDTH     = 13,
    parameter int BRAM_WE_WIDTH       = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [BRAM_DATA_WIDTH-1:0] s_data_ref,
    input  logic [BRAM_DATA_WIDTH-1:0] s_data_search,
    output logic                       en_ref,
    output logic                       en_search,
    output logic [BRAM_WE_WIDTH-1:0]   we_ref,
    output logic [BRAM_WE_WIDTH-1:0]   we_search,
    output logic [BRAM_ADDR_WIDTH-1:0] addr_ref,
    output logic [BRAM_ADDR_WIDTH-1:0] addr_search,
    output logic [BRAM_DATA_WIDTH-1:0] din_ref,
    output logic [BRAM_DATA_WIDTH-1:0] din_search,
    output logic                       busy_ref,
    output logic                       busy_search,
    output logic                       go,
    input  logic                       finished_row,
`ifdef LOADER_ROWCNT_EN
    output logic [$clog2(VRES+1)-1:0]  rows_loaded,
    output logic                       frame_done
`else
    output logic                       frame_done
`endif
);

    localparam int COL_W      = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int ROW_W      = $clog2(VRES + 1);
    localparam int PRIME_ROWS = (VRES < NUM_OF_ROWS_IN_BRAM) ? VRES : NUM_OF_ROWS_IN_BRAM;
    localparam int DONE_CNT   = (VRES >= NUM_OF_ROWS_IN_BRAM) ? (VRES - NUM_OF_ROWS_IN_BRAM + 1) : 1;

    localparam logic [COL_W-1:0]           COL_LAST  = COL_W'(HRES - 1);
    localparam logic [ROW_W-1:0]           ROW_PRIME = ROW_W'(PRIME_ROWS);
    localparam logic [ROW_W-1:0]           ROW_VRES  = ROW_W'(VRES);
    localparam logic [ROW_W-1:0]           ROW_DONE  = ROW_W'(DONE_CNT);
    localparam logic [BRAM_ADDR_WIDTH-1:0] HRES_A    = BRAM_ADDR_WIDTH'(HRES);
    localparam logic [BRAM_ADDR_WIDTH-1:0] BASE_LAST = BRAM_ADDR_WIDTH'((NUM_OF_ROWS_IN_BRAM - 1) * HRES);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRIME  = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_REFILL = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    logic [2:0]                 state;
    logic [COL_W-1:0]           col;
    logic [BRAM_ADDR_WIDTH-1:0] row_base;
    logic [ROW_W-1:0]           row_cnt;
    logic [ROW_W-1:0]           cons_cnt;
    logic                       wr_en;
    logic [BRAM_ADDR_WIDTH-1:0] wr_addr;
    logic [BRAM_DATA_WIDTH-1:0] wr_ref;
    logic [BRAM_DATA_WIDTH-1:0] wr_search;
    logic                       go_q;
    logic                       done_q;

    logic [ROW_W-1:0]           row_nxt;
    logic [ROW_W-1:0]           cons_nxt;
    logic                       loading;

    // row_base tracks slot*HRES incrementally so no multiplier is needed
    assign row_nxt  = row_cnt + ROW_W'(1);
    assign cons_nxt = cons_cnt + ROW_W'(1);
    assign loading  = (state == ST_PRIME) || (state == ST_REFILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            col       <= '0;
            row_base  <= '0;
            row_cnt   <= '0;
            cons_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_ref    <= '0;
            wr_search <= '0;
            go_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_en  <= 1'b0;
            done_q <= 1'b0;
            // go rises once the final priming write has left the port
            if (wr_en && ((state == ST_RUN) || (state == ST_DRAIN)))
                go_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (frame_start && !finished_row) begin
                        state    <= ST_PRIME;
                        col      <= '0;
                        row_base <= '0;
                        row_cnt  <= '0;
                        cons_cnt <= '0;
                    end
                end
                ST_PRIME, ST_REFILL: begin
                    if (s_valid) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= row_base + BRAM_ADDR_WIDTH'(col);
                        wr_ref    <= s_data_ref;
                        wr_search <= s_data_search;
                        if (col == COL_LAST) begin
                            col      <= '0;
                            row_base <= (row_base == BASE_LAST) ? '0 : row_base + HRES_A;
                            row_cnt  <= row_nxt;
                            if (state == ST_REFILL)
                                state <= ST_RUN;
                            else if (row_nxt == ROW_VRES)
                                state <= ST_DRAIN;
                            else if (row_nxt == ROW_PRIME)
                                state <= ST_RUN;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (finished_row) begin
                        cons_cnt <= cons_nxt;
                        if (cons_nxt >= ROW_DONE) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                            go_q   <= 1'b0;
                        end else if (row_cnt < ROW_VRES) begin
                            state <= ST_REFILL;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready     = loading;
    assign en_ref      = wr_en;
    assign en_search   = wr_en;
    assign we_ref      = {BRAM_WE_WIDTH{wr_en}};
    assign we_search   = {BRAM_WE_WIDTH{wr_en}};
    assign addr_ref    = wr_addr;
    assign addr_search = wr_addr;
    assign din_ref     = wr_ref;
    assign din_search  = wr_search;
    assign busy_ref    = (state == ST_IDLE) || loading || wr_en;
    assign busy_search = (state == ST_IDLE) || loading || wr_en;
    assign go          = go_q;
    assign frame_done  = done_q;

`ifdef LOADER_ROWCNT_EN
    assign rows_loaded = row_cnt;
`endif

endmodule

// File: tb/tb_stereo_bram_loader.sv
// Randomized bench for stereo_bram_loader: writes are scored against a queue of expected
// (slot*HRES+col, pixel) tuples; control outputs are checked at frame milestones.
module tb_stereo_bram_loader;

    localparam int HRES = 8;
    localparam int VRES = 12;
    localparam int NR   = 4;
    localparam int AW   = 5;
    localparam int DW   = 16;
    localparam int WEW  = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data_ref;
    logic [DW-1:0] s_data_search;
    logic          en_ref, en_search;
    logic [WEW-1:0] we_ref, we_search;
    logic [AW-1:0] addr_ref, addr_search;
    logic [DW-1:0] din_ref, din_search;
    logic          busy_ref, busy_search;
    logic          go;
    logic          finished_row;
    logic          frame_done;

    stereo_bram_loader #(
        .NUM_OF_ROWS_IN_BRAM(NR),
        .HRES(HRES),
        .VRES(VRES),
        .BRAM_DATA_WIDTH(DW),
        .BRAM_ADDR_WIDTH(AW),
        .BRAM_WE_WIDTH(WEW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data_ref(s_data_ref),
        .s_data_search(s_data_search),
        .en_ref(en_ref),
        .en_search(en_search),
        .we_ref(we_ref),
        .we_search(we_search),
        .addr_ref(addr_ref),
        .addr_search(addr_search),
        .din_ref(din_ref),
        .din_search(din_search),
        .busy_ref(busy_ref),
        .busy_search(busy_search),
        .go(go),
        .finished_row(finished_row),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [DW-1:0] dref;
        logic [DW-1:0] dsrch;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_on  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Write-port scoreboard: every enabled cycle must match the next accepted beat in order
    always @(negedge clk) begin
        if (mon_on) begin
            check("en_pair", 32'(en_search), 32'(en_ref));
            check("we_ref", 32'(we_ref), 32'(en_ref));
            check("we_search", 32'(we_search), 32'(en_ref));
            if (en_ref) begin
                if (exp_q.size() == 0) begin
                    check("spurious_wr", 32'(addr_ref), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("addr_ref", 32'(addr_ref), 32'(mon_e.addr));
                    check("addr_search", 32'(addr_search), 32'(mon_e.addr));
                    check("din_ref", 32'(din_ref), 32'(mon_e.dref));
                    check("din_search", 32'(din_search), 32'(mon_e.dsrch));
                end
            end
        end
    end

    // Drives one row's beats starting at the current negedge; returns at the negedge after the last accept
    task automatic send_row(input int row, input int nbeats, input bit bp);
        int   beats  = 0;
        int   cycles = 0;
        exp_t e;
        while (beats < nbeats && cycles < 400) begin
            s_valid       = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data_ref    = DW'($urandom);
            s_data_search = DW'($urandom);
            if (s_valid && s_ready) begin
                e.addr  = (row % NR) * HRES + beats;
                e.dref  = s_data_ref;
                e.dsrch = s_data_search;
                exp_q.push_back(e);
                beats++;
            end
            cycles++;
            @(negedge clk);
        end
        if (beats < nbeats) check("row_timeout", 32'(beats), 32'(nbeats));
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_finished_row();
        finished_row = 1'b1;
        @(negedge clk);
        finished_row = 1'b0;
    endtask

    task automatic run_frame(input bit bp);
        pulse_frame_start();
        check("prime_ready", 32'(s_ready), 32'd1);
        pulse_finished_row();
        check("prime_fr_ready", 32'(s_ready), 32'd1);
        check("prime_fr_go", 32'(go), 32'd0);
        for (int r = 0; r < NR; r++) send_row(r, HRES, bp);
        s_valid = 1'b0;
        check("prime_end_ready", 32'(s_ready), 32'd0);
        check("prime_end_go", 32'(go), 32'd0);
        check("prime_end_busy", 32'(busy_ref), 32'd1);
        @(negedge clk);
        check("go_rise", 32'(go), 32'd1);
        check("busy_fall_ref", 32'(busy_ref), 32'd0);
        check("busy_fall_search", 32'(busy_search), 32'd0);
        pulse_frame_start();
        @(negedge clk);
        check("run_fs_ready", 32'(s_ready), 32'd0);
        check("run_fs_go", 32'(go), 32'd1);
        check("run_fs_busy", 32'(busy_ref), 32'd0);
        for (int r = NR; r < VRES; r++) begin
            pulse_finished_row();
            check("refill_ready", 32'(s_ready), 32'd1);
            check("refill_busy", 32'(busy_search), 32'd1);
            check("refill_go", 32'(go), 32'd1);
            send_row(r, HRES, bp);
            s_valid = 1'b1;
            check("row_end_ready", 32'(s_ready), 32'd0);
            @(negedge clk);
            check("row_end_ready2", 32'(s_ready), 32'd0);
            check("row_end_busy", 32'(busy_ref), 32'd0);
            s_valid = 1'b0;
        end
        pulse_finished_row();
        check("frame_done", 32'(frame_done), 32'd1);
        check("done_go", 32'(go), 32'd0);
        check("done_busy", 32'(busy_ref), 32'd1);
        check("done_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("frame_done_pulse", 32'(frame_done), 32'd0);
        check("frame_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        frame_start   = 1'b0;
        finished_row  = 1'b0;
        s_valid       = 1'b0;
        s_data_ref    = '0;
        s_data_search = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_en", 32'({en_ref, en_search}), 32'd0);
        check("rst_we", 32'({we_ref, we_search}), 32'd0);
        check("rst_addr", 32'({addr_ref, addr_search}), 32'd0);
        check("rst_din", 32'({din_ref, din_search}), 32'd0);
        check("rst_busy", 32'({busy_ref, busy_search}), 32'd3);
        check("rst_go", 32'(go), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        reset  = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        pulse_finished_row();
        @(negedge clk);
        check("idle_fr_ready", 32'(s_ready), 32'd0);
        check("idle_fr_go", 32'(go), 32'd0);
        check("idle_fr_busy", 32'(busy_ref), 32'd1);

        run_frame(1'b1);

        pulse_frame_start();
        send_row(0, HRES, 1'b0);
        send_row(1, 5, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_en", 32'(en_ref), 32'd0);
        check("midrst_we", 32'(we_ref), 32'd0);
        check("midrst_go", 32'(go), 32'd0);
        check("midrst_busy", 32'(busy_ref), 32'd1);
        check("midrst_ready", 32'(s_ready), 32'd0);
        check("midrst_addr", 32'(addr_ref), 32'd0);
        reset   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("midrst_q_empty", 32'(exp_q.size()), 32'd0);

        run_frame(1'b0);

        repeat (2) @(negedge clk);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
